// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the UART TX arbiter, its byte producers and the UART transmitter.
// master = arbiter side, slave = producers plus UART side.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        o_grant;
   logic                      o_busy;
   logic                      o_start;
   logic [DATA_W-1:0]         o_tx_data;
   logic                      i_tx_done;
   logic                      o_timeout;

   modport master (
      input  req, req_data, i_tx_done,
      output ack, o_grant, o_busy, o_start, o_tx_data, o_timeout
   );

   modport slave (
      output req, req_data, i_tx_done,
      input  ack, o_grant, o_busy, o_start, o_tx_data, o_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional BUSY watchdog is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input logic               clk,
   input logic               reset,
   uart_tx_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
   end

   state_t             state_r;
   logic [PTR_W-1:0]   ptr_r;
   logic [PTR_W-1:0]   winner_r;
   logic [PTR_W-1:0]   pick_idx_s;
   logic [PTR_W-1:0]   next_ptr_s;
   logic               pick_vld_s;
   logic [NUM_REQ-1:0] ack_r;
   logic [NUM_REQ-1:0] grant_r;
   logic               busy_r;
   logic               start_r;
   logic [DATA_W-1:0]  tx_data_r;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
   logic [WD_W-1:0] wd_cnt_r;
   logic            timeout_r;
`endif

   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
      int sum_v;
      sum_v = int'(base) + offset;
      if (sum_v >= NUM_REQ) begin
         rr_index = PTR_W'(sum_v - NUM_REQ);
      end else begin
         rr_index = PTR_W'(sum_v);
      end
   endfunction

   // Search from ptr_r upward; iterating downward lets the smallest offset overwrite last
   always_comb begin
      pick_vld_s = 1'b0;
      pick_idx_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pick_idx_s = bus.req[rr_index(ptr_r, k)] ? rr_index(ptr_r, k) : pick_idx_s;
         pick_vld_s = pick_vld_s | bus.req[rr_index(ptr_r, k)];
      end
   end

   // Pointer moves one past the served requester so it ranks last next time
   always_comb begin
      if (winner_r == PTR_W'(NUM_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = winner_r + PTR_W'(1);
      end
   end

   // Arbitration / sequencing FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         ptr_r     <= '0;
         winner_r  <= '0;
         ack_r     <= '0;
         grant_r   <= '0;
         busy_r    <= 1'b0;
         start_r   <= 1'b0;
         tx_data_r <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         wd_cnt_r  <= '0;
         timeout_r <= 1'b0;
`endif
      end else begin
         ack_r   <= '0;
         start_r <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         timeout_r <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (pick_vld_s) begin
                  winner_r  <= pick_idx_s;
                  grant_r   <= ONE_HOT_0 << pick_idx_s;
                  tx_data_r <= bus.req_data[int'(pick_idx_s) * DATA_W +: DATA_W];
                  busy_r    <= 1'b1;
                  state_r   <= ST_START;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_START: begin
               start_r <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
               wd_cnt_r <= '0;
`endif
               state_r <= ST_BUSY;
            end
            ST_BUSY: begin
               if (bus.i_tx_done) begin
                  ack_r   <= grant_r;
                  ptr_r   <= next_ptr_s;
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (wd_cnt_r == WD_MAX) begin
                  timeout_r <= 1'b1;
                  ptr_r     <= next_ptr_s;
                  grant_r   <= '0;
                  busy_r    <= 1'b0;
                  state_r   <= ST_IDLE;
               end else begin
                  wd_cnt_r  <= wd_cnt_r + WD_W'(1);
                  state_r   <= ST_BUSY;
               end
`else
               else begin
                  state_r <= ST_BUSY;
               end
`endif
            end
            default: begin
               grant_r <= '0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = ack_r;
   assign bus.o_grant   = grant_r;
   assign bus.o_busy    = busy_r;
   assign bus.o_start   = start_r;
   assign bus.o_tx_data = tx_data_r;
`ifdef UART_TX_ARB_TIMEOUT_EN
   assign bus.o_timeout = timeout_r;
`else
   assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model, directed scenarios and random traffic.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 8;
   localparam int TIMEOUT_CYC = 100;

   logic clk = 1'b0;
   logic reset;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [NUM_REQ-1:0]        req_v;
   logic [NUM_REQ-1:0]        hold_v;
   logic [NUM_REQ*DATA_W-1:0] data_v;
   logic                      done_v;
   bit                        suppress_done;
   bit                        stray_en;
   int                        uart_cnt;
   int                        dly_min;
   int                        dly_max;

   // Reference model: one transfer record aged in cycles since its grant
   bit                 m_active;
   int                 m_win;
   int                 m_age;
   int                 m_ptr;
   logic [DATA_W-1:0]  m_byte;
   logic [NUM_REQ-1:0] m_ack;
   bit                 m_start;
   bit                 m_to;
   int                 cyc;

   logic [DATA_W-1:0] start_log[$];
   int                start_cyc[$];
   int                ack_log[$];
   int                ack_cyc[$];
   int                grant_log[$];
   int                to_cyc[$];

   int n_cmp;
   int n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_win    = 0;
      m_age    = 0;
      m_ptr    = 0;
      m_byte   = '0;
      m_ack    = '0;
      m_start  = 1'b0;
      m_to     = 1'b0;
   endtask

   task automatic model_edge();
      cyc++;
      m_ack   = '0;
      m_start = 1'b0;
      m_to    = 1'b0;
      if (!reset) begin
         model_reset();
      end else if (m_active) begin
         if (m_age >= 1 && done_v) begin
            m_ack[m_win] = 1'b1;
            m_active     = 1'b0;
            m_ptr        = (m_win + 1) % NUM_REQ;
            ack_log.push_back(m_win);
            ack_cyc.push_back(cyc);
         end
`ifdef UART_TX_ARB_TIMEOUT_EN
         else if (m_age >= 1 && m_age - 1 == TIMEOUT_CYC) begin
            m_to     = 1'b1;
            m_active = 1'b0;
            m_ptr    = (m_win + 1) % NUM_REQ;
            to_cyc.push_back(cyc);
         end
`endif
         else begin
            m_age++;
            if (m_age == 1) begin
               m_start = 1'b1;
               start_log.push_back(m_byte);
               start_cyc.push_back(cyc);
            end
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (!m_active && req_v[idx]) begin
               m_active = 1'b1;
               m_win    = idx;
               m_age    = 0;
               m_byte   = data_v[idx*DATA_W +: DATA_W];
               grant_log.push_back(idx);
            end
         end
      end
   endtask

   task automatic compare_outputs();
      logic [NUM_REQ-1:0] exp_grant;
      exp_grant = '0;
      if (m_active) exp_grant[m_win] = 1'b1;
      check("ack", bus.ack, m_ack);
      check("grant", bus.o_grant, exp_grant);
      check("busy", bus.o_busy, m_active);
      check("start", bus.o_start, m_start);
      check("tx_data", bus.o_tx_data, m_byte);
      check("timeout", bus.o_timeout, m_to);
   endtask

   // Requesters drop on ack unless holding; UART stub answers start after a delay
   task automatic drive_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (m_ack[i] && !hold_v[i]) req_v[i] = 1'b0;
      end
      if (m_start && !suppress_done) uart_cnt = $urandom_range(dly_max, dly_min);
      done_v = 1'b0;
      if (m_active && m_age >= 1 && uart_cnt != 0) begin
         done_v = (uart_cnt == 1);
         uart_cnt--;
      end else if (stray_en && (!m_active || m_age == 0) && $urandom_range(0, 7) == 0) begin
         done_v = 1'b1;
      end
      bus.req       = req_v;
      bus.req_data  = data_v;
      bus.i_tx_done = done_v;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   task automatic cycle();
      drive_inputs();
      step();
   endtask

   task automatic run_until_acks(input int target, input string name);
      int t;
      t = 0;
      while (ack_log.size() < target && t < 300) begin
         cycle();
         t++;
      end
      check(name, ack_log.size(), target);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((m_active || req_v != '0) && t < 400) begin
         cycle();
         t++;
      end
      check(name, {31'd0, (m_active || req_v != '0)}, 32'd0);
   endtask

   initial begin
      int a0, s0, g0, t0;
      bit raised;
      n_cmp = 0; n_bad = 0; cyc = 0;
      req_v = '0; hold_v = '0; data_v = '0; done_v = 1'b0;
      suppress_done = 1'b0; stray_en = 1'b0; uart_cnt = 0;
      dly_min = 3; dly_max = 3;
      reset = 1'b0;
      model_reset();
      bus.req = '0; bus.req_data = '0; bus.i_tx_done = 1'b0;
      @(negedge clk);
      check("rst_grant", bus.o_grant, 32'd0);
      check("rst_busy", bus.o_busy, 32'd0);
      check("rst_tx_data", bus.o_tx_data, 32'd0);
      step(); step();
      reset = 1'b1;

      // Single request
      a0 = ack_log.size(); s0 = start_log.size();
      req_v = 4'b0001; data_v[7:0] = 8'h01;
      run_until_acks(a0 + 1, "single_done");
      check("single_starts", start_log.size(), s0 + 1);
      check("single_byte", start_log[$], 8'h01);
      check("single_ack_idx", ack_log[$], 32'd0);
      cycle();

      // Reset so the pointer is back at 0, then all four at once
      reset = 1'b0; model_reset(); step(); reset = 1'b1;
      a0 = ack_log.size(); s0 = start_log.size();
      data_v = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_v = 4'b1111;
      run_until_acks(a0 + 4, "all4_done");
      for (int k = 0; k < 4; k++) begin
         logic [7:0] exp_b;
         exp_b = 8'hA0 + 8'(k);
         check("all4_order", start_log[s0 + k], exp_b);
         check("all4_ack_order", ack_log[a0 + k], k);
      end
      for (int k = 0; k < 3; k++) begin
         check("all4_ack_to_start", start_cyc[s0 + k + 1] - ack_cyc[a0 + k], 32'd2);
      end
      wait_idle("all4_idle");

      // Fairness: 0 holds continuously, 2 arrives during 0's transfer
      g0 = grant_log.size(); raised = 1'b0; t0 = 0;
      hold_v = 4'b0001; req_v = 4'b0001;
      data_v[7:0] = 8'h10; data_v[23:16] = 8'h12;
      while (grant_log.size() < g0 + 3 && t0 < 300) begin
         if (grant_log.size() >= g0 + 1 && !raised) begin
            req_v[2] = 1'b1;
            raised = 1'b1;
         end
         cycle();
         t0++;
      end
      check("fair_grants", grant_log.size(), g0 + 3);
      hold_v = '0;
      if (grant_log.size() >= g0 + 3) begin
         check("fair_g0", grant_log[g0], 32'd0);
         check("fair_g1", grant_log[g0 + 1], 32'd2);
         check("fair_g2", grant_log[g0 + 2], 32'd0);
      end
      wait_idle("fair_idle");

      // Data latched at grant only
      req_v = 4'b0001; data_v[7:0] = 8'h55; t0 = 0;
      while (!m_active && t0 < 20) begin cycle(); t0++; end
      data_v[7:0] = 8'hAA;
      wait_idle("latch_idle");
      check("latch_byte", start_log[$], 8'h55);
      check("latch_hold", bus.o_tx_data, 8'h55);

      // Reset in the middle of BUSY
      req_v = 4'b0001; data_v[7:0] = 8'h3C; t0 = 0;
      while (!(m_active && m_age == 3) && t0 < 30) begin cycle(); t0++; end
      check("mid_busy_reached", m_age, 32'd3);
      drive_inputs();
      #2 reset = 1'b0;
      #1;
      check("mid_rst_ack", bus.ack, 32'd0);
      check("mid_rst_grant", bus.o_grant, 32'd0);
      check("mid_rst_busy", bus.o_busy, 32'd0);
      check("mid_rst_start", bus.o_start, 32'd0);
      check("mid_rst_tx", bus.o_tx_data, 32'd0);
      check("mid_rst_to", bus.o_timeout, 32'd0);
      model_reset(); req_v = '0; uart_cnt = 0;
      bus.req = '0;
      step(); step();
      reset = 1'b1;
      a0 = ack_log.size();
      req_v = 4'b0100; data_v[23:16] = 8'h77;
      run_until_acks(a0 + 1, "post_rst_done");
      check("post_rst_grant", grant_log[$], 32'd2);
      check("post_rst_byte", start_log[$], 8'h77);
      cycle();

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Watchdog expiry with done withheld, then stray done pulses in IDLE
      suppress_done = 1'b1; stray_en = 1'b0;
      t0 = to_cyc.size(); a0 = ack_log.size();
      req_v = 4'b0010; data_v[15:8] = 8'h5A;
      for (int t = 0; t < 300 && to_cyc.size() == t0; t++) cycle();
      check("to_fired", to_cyc.size(), t0 + 1);
      if (to_cyc.size() > t0) check("to_latency", to_cyc[$] - start_cyc[$], 32'd101);
      check("to_no_ack", ack_log.size(), a0);
      req_v = '0; suppress_done = 1'b0; stray_en = 1'b1;
      for (int t = 0; t < 20; t++) cycle();
      check("to_idle_busy", bus.o_busy, 32'd0);
`endif

      // Random traffic with early drops, post-grant data churn and stray done pulses
      stray_en = 1'b1; dly_min = 1; dly_max = 6;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_v[i] && $urandom_range(0, 3) == 0) begin
               req_v[i] = 1'b1;
               data_v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end else if (m_active && m_win == i && m_age >= 1) begin
               data_v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               if ($urandom_range(0, 7) == 0) req_v[i] = 1'b0;
            end
         end
         cycle();
      end
      wait_idle("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (`top_uart` TX path) between `NUM_REQ` byte producers. It grants one requester at a time and latches its byte. It drives the UART `start` and `tx_data` inputs, then waits for `o_tx_done` before acknowledging the requester and moving to the next one. It sits between the application producers and `top_uart` inside the FPGA top level.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `DATA_W`, default 8: byte width; must match the UART `tx_data` width.
- `TIMEOUT_CYC`, default 200000: maximum number of BUSY cycles to wait for `i_tx_done`. Used only when the timeout feature is compiled in.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, `NUM_REQ`: level request, one bit per requester.
- `req_data`, input, `NUM_REQ*DATA_W`: requester i's byte is at bits `[i*DATA_W +: DATA_W]`.
- `ack`, output, `NUM_REQ`: one-cycle pulse on the granted bit when its byte has been transmitted.
- `o_grant`, output, `NUM_REQ`: one-hot current grant; all zero in IDLE.
- `o_busy`, output, 1: high in any state other than IDLE.
- `o_start`, output, 1: connects to UART `start`; one-cycle pulse.
- `o_tx_data`, output, `DATA_W`: connects to UART `tx_data`; holds the latched byte.
- `i_tx_done`, input, 1: connects to UART `o_tx_done`; a one-cycle pulse.
- `o_timeout`, output, 1: one-cycle pulse on watchdog expiry.

## Operation
- There are three states: IDLE, START and BUSY.
- IDLE: if any `req` bit is high, select the winner by round-robin search starting at pointer `ptr` and wrapping upward.
  - Register the winner into `o_grant`.
  - Latch that requester's byte into `o_tx_data`.
  - Go to START.
  - If no `req` bit is high, stay in IDLE.
- START: `o_start` = 1 for exactly this one cycle. Clear the watchdog counter. Go to BUSY.
- BUSY: wait for `i_tx_done`.
  - On `i_tx_done` = 1: pulse `ack` on the granted bit, set `ptr` = winner + 1 (mod `NUM_REQ`), clear `o_grant`, go to IDLE.
- The pointer rule gives the most recently served requester the lowest priority next time. A requester that holds `req` continuously cannot starve the others.
- Requester rules:
  - A requester holds `req` high until it sees `ack`.
  - `req_data` is sampled only at grant. Changes after grant are ignored.
  - Dropping `req` after grant does not abort the transfer; the byte is still sent and `ack` still pulses.
- `i_tx_done` in IDLE or START is ignored.
- `o_tx_data` keeps its last value in IDLE. It is never cleared except by reset.

## Timing
- Reset (while `reset` is low, asynchronous):
  - State = IDLE, `ptr` = 0.
  - `ack`, `o_grant`, `o_busy`, `o_start`, `o_timeout` = 0.
  - `o_tx_data` = 0.
- Reset mid-transfer: the arbiter returns to IDLE immediately and no `ack` is issued. The UART is reset separately.
- Latency:
  - `req` sampled high at clock edge E0 (in IDLE) → `o_grant` and `o_busy` high after E0.
  - `o_start` high for the cycle after E1.
  - `i_tx_done` sampled high at edge En → `ack` high for the cycle after En, together with `o_busy` = 0.
- Back-to-back transfers: at least one IDLE cycle separates `ack` from the next grant.
  - The new grant is registered at the edge after `ack` rises.
  - The gap from `ack` to the next `o_start` is 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A watchdog counter runs in BUSY. Its width is `$clog2(TIMEOUT_CYC+1)`, it starts at 0 and saturates.
  - If the counter reaches `TIMEOUT_CYC` with no `i_tx_done`: pulse `o_timeout` for one cycle, issue no `ack`, advance `ptr` past the winner, clear `o_grant`, go to IDLE.
  - If `i_tx_done` and expiry fall in the same cycle, done wins: `ack` pulses and `o_timeout` stays 0.
- Undefined: no counter is built, `o_timeout` is tied to 0, and BUSY waits indefinitely.

## Test plan
- Single request, with `top_uart` TX looped back to RX: `req` = 0001, byte 0x01 → `o_start` pulses once with `o_tx_data` = 0x01, and `ack`[0] pulses after `i_tx_done`. RX receives 0x01.
- Simultaneous requests: `req` = 1111 with bytes 0xA0, 0xA1, 0xA2, 0xA3 and `ptr` = 0 → transmission order is 0xA0, 0xA1, 0xA2, 0xA3. Each requester drops `req` after its own `ack`; `ack` bits pulse in the order 0, 1, 2, 3.
- Fairness: requester 0 holds `req` continuously while requester 2 raises `req` during requester 0's transfer. The next grant goes to requester 2, then back to 0; requester 0 never gets two grants in a row while 2 is waiting.
- Data latch: `req_data`[0] changes from 0x55 to 0xAA one cycle after grant → 0x55 is transmitted.
- Reset mid-BUSY: pull `reset` low during BUSY → all outputs are 0 immediately and no `ack` is issued. After reset is released with `req` = 0100, requester 2 is granted.
- With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYC` = 100, `i_tx_done` held at 0 → `o_timeout` pulses exactly 101 cycles after `o_start`, no `ack` is issued, and `o_busy` falls. A stray `i_tx_done` sent in IDLE has no effect.
